// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern controller: FSM states,
// the pattern table and index helpers.
package led_pkg;

  localparam int NPAT   = 8;
  localparam int IDX_W  = $clog2(NPAT);
  localparam int CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam logic [7:0] PAT_TABLE [NPAT] = '{
    8'h01, 8'h81, 8'h03, 8'h0F, 8'h55, 8'h33, 8'h18, 8'hFF
  };

  // NPAT is a power of two, so the natural wrap of the index gives 7 -> 0
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/led_pattern_ctrl_if.sv
// Control-side signal bundle between the pattern controller (master) and
// the board/rotator side (slave).
interface led_pattern_ctrl_if;
  import led_pkg::*;

  logic             key_n;
  logic             run;
  logic [7:0]       load_data;
  logic             nload;
  logic             shift_tick;
  logic [IDX_W-1:0] pat_idx;

  modport master (
    input  key_n, run,
    output load_data, nload, shift_tick, pat_idx
  );

  modport slave (
    output key_n, run,
    input  load_data, nload, shift_tick, pat_idx
  );

endinterface

// File: rtl/key_debounce.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a
// one-cycle pulse on each accepted press (1 -> 0 of the debounced level).
module key_debounce #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic nrst,
  input  logic key_n,
  output logic key_db,
  output logic press
);

  localparam int              CNT_W   = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic             sync1_r;
  logic             sync2_r;
  logic             key_db_r;
  logic             press_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchronize, then accept a new level only after DEB_CYCLES differing samples
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sync1_r  <= 1'b1;
      sync2_r  <= 1'b1;
      key_db_r <= 1'b1;
      press_r  <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
    end else begin
      sync1_r <= key_n;
      sync2_r <= sync1_r;
      press_r <= 1'b0;
      if (sync2_r == key_db_r) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_MAX) begin
        key_db_r <= sync2_r;
        cnt_r    <= {CNT_W{1'b0}};
        press_r  <= ~sync2_r;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign key_db = key_db_r;
  assign press  = press_r;

endmodule

// File: rtl/led_pattern_ctrl.sv
// Pattern controller: steps an 8-entry table on each debounced press, issues
// a registered active-low load strobe and paces the rotator with shift_tick.
module led_pattern_ctrl
  import led_pkg::*;
#(
  parameter int STEP_DIV   = CLK_HZ,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               nrst,
  led_pattern_ctrl_if.master bus
);

  localparam int               DIV_W   = $clog2(STEP_DIV);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(STEP_DIV - 1);

  logic             key_db_s;
  logic             press_s;
  state_t           state_r;
  logic [DIV_W-1:0] div_r;
  logic [IDX_W-1:0] idx_r;
  logic [7:0]       data_r;
  logic             nload_r;
  logic             tick_r;

  key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_key (
    .clk    (clk),
    .nrst   (nrst),
    .key_n  (bus.key_n),
    .key_db (key_db_s),
    .press  (press_s)
  );

  // Sequencer, divider and all registered outputs; nload lags the LOAD state by one edge
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r <= ST_INIT;
      div_r   <= {DIV_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      data_r  <= PAT_TABLE[0];
      nload_r <= 1'b1;
      tick_r  <= 1'b0;
    end else begin
      nload_r <= 1'b1;
      tick_r  <= 1'b0;
      case (state_r)
        ST_INIT: begin
          div_r   <= {DIV_W{1'b0}};
          state_r <= ST_LOAD;
        end
        ST_LOAD: begin
          div_r   <= {DIV_W{1'b0}};
          nload_r <= 1'b0;
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (bus.run) begin
            if (div_r == DIV_MAX) begin
              div_r  <= {DIV_W{1'b0}};
              tick_r <= 1'b1;
            end else begin
              div_r <= div_r + DIV_W'(1);
            end
          end
          if (press_s && !key_db_s) begin
            idx_r   <= next_idx(idx_r);
            data_r  <= PAT_TABLE[next_idx(idx_r)];
            state_r <= ST_LOAD;
          end
        end
        default: begin
          div_r   <= {DIV_W{1'b0}};
          state_r <= ST_INIT;
        end
      endcase
    end
  end

  assign bus.load_data  = data_r;
  assign bus.nload      = nload_r;
  assign bus.shift_tick = tick_r;
  assign bus.pat_idx    = idx_r;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Self-checking bench for led_pattern_ctrl: edge-count reference model,
// directed scenarios with literal expectations and a randomized phase.
module tb_led_pattern_ctrl;

  localparam int STEP_DIV = 4;
  localparam int DEB      = 3;

  logic clk  = 1'b0;
  logic nrst = 1'b0;

  led_pattern_ctrl_if bus ();

  led_pattern_ctrl #(.STEP_DIV(STEP_DIV), .DEB_CYCLES(DEB)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_tab [8] = '{8'h01, 8'h81, 8'h03, 8'h0F, 8'h55, 8'h33, 8'h18, 8'hFF};
  logic [7:0] load_log [$];

  // Reference model: time is counted in edges since reset release
  bit m_valid = 1'b0;
  int m_n, m_load_edge, m_run_cnt, m_idx, m_streak;
  bit m_tick, m_press_pend, m_k1, m_k2, m_db, m_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (!nrst) begin
      m_valid = 1'b1; m_n = 0; m_load_edge = 2; m_run_cnt = 0; m_idx = 0;
      m_tick = 1'b0; m_press_pend = 1'b0; m_k1 = 1'b1; m_k2 = 1'b1;
      m_db = 1'b1; m_streak = 0;
    end else if (m_valid) begin
      m_n++;
      m_tick = 1'b0;
      if (m_n > m_load_edge) begin
        if (bus.run) begin
          m_run_cnt++;
          if (m_run_cnt % STEP_DIV == 0) m_tick = 1'b1;
        end
        if (m_press_pend) begin
          m_idx = (m_idx + 1) % 8;
          m_load_edge = m_n + 1;
          m_run_cnt = 0;
        end
      end
      m_s = m_k2; m_k2 = m_k1; m_k1 = bus.key_n;
      m_press_pend = 1'b0;
      if (m_s == m_db) m_streak = 0;
      else begin
        m_streak++;
        if (m_streak == DEB) begin
          m_db = m_s; m_streak = 0; m_press_pend = !m_s;
        end
      end
    end
  end

  // Single compare process: every cycle once the model has seen a reset
  always @(negedge clk) begin
    if (m_valid) begin
      check("nload",      {31'd0, bus.nload},      {31'd0, (m_n == m_load_edge) ? 1'b0 : 1'b1});
      check("shift_tick", {31'd0, bus.shift_tick}, {31'd0, m_tick});
      check("pat_idx",    {29'd0, bus.pat_idx},    32'(m_idx));
      check("load_data",  {24'd0, bus.load_data},  {24'd0, ref_tab[m_idx]});
      if (bus.nload === 1'b0) load_log.push_back(bus.load_data);
    end
  end

  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b0; cyc(2); nrst = 1'b1;
  endtask

  task automatic press_key(input int low, input int high);
    bus.key_n = 1'b0; cyc(low); bus.key_n = 1'b1; cyc(high);
  endtask

  logic [7:0] exp_seq [8] = '{8'h81, 8'h03, 8'h0F, 8'h55, 8'h33, 8'h18, 8'hFF, 8'h01};

  initial begin
    int tcount, cl, ct, nl, base, waited;
    bus.key_n = 1'b1; bus.run = 1'b1;
    @(negedge clk);
    do_reset();

    // Startup: LOAD of 01 on edge 2, ticks on edges 6, 10, 14
    cyc(2);
    check("init_nload", {31'd0, bus.nload}, 32'd0);
    check("init_data",  {24'd0, bus.load_data}, 32'h01);
    tcount = 0;
    for (int e = 3; e <= 14; e++) begin
      cyc(1);
      if (bus.shift_tick) begin
        tcount++;
        check("init_tick_pos", 32'(e % 4), 32'd2);
      end
    end
    check("init_tick_count", 32'(tcount), 32'd3);
    check("init_idx", {29'd0, bus.pat_idx}, 32'd0);

    // Long press: nload 6 edges after key falls, next tick 4 after the load
    cl = -1; ct = -1; nl = 0;
    bus.key_n = 1'b0;
    for (int c = 0; c < 40; c++) begin
      cyc(1);
      if (c == 10) bus.key_n = 1'b1;
      if (bus.nload === 1'b0) begin cl = c; nl++; end
      if (bus.shift_tick && cl >= 0 && ct < 0) ct = c;
    end
    check("press_nload_delay", 32'(cl), 32'd6);
    check("press_nload_count", 32'(nl), 32'd1);
    check("press_to_tick", 32'(ct - cl), 32'd4);
    check("press_idx", {29'd0, bus.pat_idx}, 32'd1);
    check("press_data", {24'd0, load_log[$]}, 32'h81);

    // Two-cycle glitch is ignored
    base = load_log.size();
    press_key(2, 15);
    check("glitch_loads", 32'(load_log.size() - base), 32'd0);
    check("glitch_idx", {29'd0, bus.pat_idx}, 32'd1);

    // Pause with divider at 2
    bus.key_n = 1'b0;
    waited = 0;
    while (bus.nload !== 1'b0 && waited < 50) begin cyc(1); waited++; end
    check("pause_wait_load", 32'(waited < 50), 32'd1);
    bus.key_n = 1'b1;
    cyc(2);
    bus.run = 1'b0;
    tcount = 0;
    for (int c = 0; c < 10; c++) begin cyc(1); if (bus.shift_tick) tcount++; end
    check("pause_ticks", 32'(tcount), 32'd0);
    bus.run = 1'b1;
    cyc(1);
    check("resume_tick1", {31'd0, bus.shift_tick}, 32'd0);
    cyc(1);
    check("resume_tick2", {31'd0, bus.shift_tick}, 32'd1);

    // Eight presses walk the whole table and wrap
    do_reset();
    cyc(4);
    base = load_log.size();
    for (int p = 0; p < 8; p++) press_key(6, 10);
    check("seq_loads", 32'(load_log.size() - base), 32'd8);
    if (load_log.size() - base == 8)
      for (int i = 0; i < 8; i++)
        check($sformatf("seq%0d", i), {24'd0, load_log[base + i]}, {24'd0, exp_seq[i]});
    check("seq_idx_wrap", {29'd0, bus.pat_idx}, 32'd0);

    // Reset mid-operation
    do_reset();
    cyc(4);
    for (int p = 0; p < 5; p++) press_key(6, 10);
    bus.key_n = 1'b0;
    cyc(2);
    check("mid_idx", {29'd0, bus.pat_idx}, 32'd5);
    nrst = 1'b0;
    cyc(1);
    bus.key_n = 1'b1;
    check("mid_rst_nload", {31'd0, bus.nload}, 32'd1);
    check("mid_rst_tick",  {31'd0, bus.shift_tick}, 32'd0);
    check("mid_rst_idx",   {29'd0, bus.pat_idx}, 32'd0);
    check("mid_rst_data",  {24'd0, bus.load_data}, 32'h01);
    nrst = 1'b1;
    cyc(2);
    check("mid_reload_nload", {31'd0, bus.nload}, 32'd0);
    check("mid_reload_data",  {24'd0, bus.load_data}, 32'h01);

    // Randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      bus.key_n = 1'($urandom_range(0, 1));
      bus.run   = ($urandom_range(0, 3) != 0);
      nrst      = ($urandom_range(0, 80) != 0);
      cyc($urandom_range(1, 8));
    end
    nrst = 1'b1; bus.key_n = 1'b1; bus.run = 1'b1;
    cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
